// File: rtl/timer_countdown_core.sv
// Countdown timer core: holds a BCD MM:SS value and counts it down once per
// clk1hz enable pulse under load / start-stop control, flagging expiry at 00:00.
module timer_countdown_core (
    input  logic       C50,
    input  logic       rst,
    input  logic       clk1hz,
    input  logic       load,
    input  logic       start_stop,
    input  logic [3:0] set_mt,
    input  logic [3:0] set_mo,
    input  logic [3:0] set_st,
    input  logic [3:0] set_so,
    output logic [3:0] mt,
    output logic [3:0] mo,
    output logic [3:0] st,
    output logic [3:0] so,
    output logic       running,
    output logic       done,
    output logic       expired
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0] state;
    logic [3:0] san_mt, san_mo, san_st, san_so;
    logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
    logic       is_zero;
    logic       is_one;

    // Clamp presets so the digit registers can never hold a non-BCD value.
    always_comb begin
        san_mt = (set_mt > 4'd9) ? 4'd9 : set_mt;
        san_mo = (set_mo > 4'd9) ? 4'd9 : set_mo;
        san_st = (set_st > 4'd5) ? 4'd5 : set_st;
        san_so = (set_so > 4'd9) ? 4'd9 : set_so;
    end

    assign is_zero = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd0);
    assign is_one  = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd1);

    // One-second decrement with borrow; only used when the value is non-zero.
    always_comb begin
        dec_mt = mt;
        dec_mo = mo;
        dec_st = st;
        dec_so = so;
        if (so != 4'd0) begin
            dec_so = so - 4'd1;
        end else begin
            dec_so = 4'd9;
            if (st != 4'd0) begin
                dec_st = st - 4'd1;
            end else begin
                dec_st = 4'd5;
                if (mo != 4'd0) begin
                    dec_mo = mo - 4'd1;
                end else begin
                    dec_mo = 4'd9;
                    dec_mt = mt - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge C50) begin
        expired <= 1'b0;
        if (rst) begin
            state <= IDLE;
            mt    <= 4'd0;
            mo    <= 4'd0;
            st    <= 4'd0;
            so    <= 4'd0;
        end else if (load) begin
            state <= IDLE;
            mt    <= san_mt;
            mo    <= san_mo;
            st    <= san_st;
            so    <= san_so;
        end else if (start_stop) begin
            case (state)
                IDLE:    if (!is_zero) state <= RUN;
                RUN:     state <= PAUSE;
                PAUSE:   state <= RUN;
                default: state <= IDLE;
            endcase
        end else if (clk1hz && (state == RUN) && !is_zero) begin
            mt <= dec_mt;
            mo <= dec_mo;
            st <= dec_st;
            so <= dec_so;
            if (is_one) begin
                state   <= DONE;
                expired <= 1'b1;
            end
        end
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_timer_countdown_core.sv
// Directed self-checking bench for timer_countdown_core; expected values are
// hand-computed BCD MM:SS words and {running, done, expired} flag triples.
module tb_timer_countdown_core;

    logic       C50 = 1'b0;
    logic       rst = 1'b0;
    logic       clk1hz = 1'b0;
    logic       load = 1'b0;
    logic       start_stop = 1'b0;
    logic [3:0] set_mt = 4'd0;
    logic [3:0] set_mo = 4'd0;
    logic [3:0] set_st = 4'd0;
    logic [3:0] set_so = 4'd0;
    logic [3:0] mt, mo, st, so;
    logic       running, done, expired;

    int checks = 0;
    int passes = 0;

    timer_countdown_core dut (
        .C50        (C50),
        .rst        (rst),
        .clk1hz     (clk1hz),
        .load       (load),
        .start_stop (start_stop),
        .set_mt     (set_mt),
        .set_mo     (set_mo),
        .set_st     (set_st),
        .set_so     (set_so),
        .mt         (mt),
        .mo         (mo),
        .st         (st),
        .so         (so),
        .running    (running),
        .done       (done),
        .expired    (expired)
    );

    always #10 C50 = ~C50;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        if (observed === expected)
            passes++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    endtask

    // Drive one cycle of pulses, then sample 1 time unit after the active edge.
    task automatic applyStimulus(input logic r, input logic ld, input logic ss,
                                 input logic tk, input logic [15:0] preset);
        @(negedge C50);
        rst        = r;
        load       = ld;
        start_stop = ss;
        clk1hz     = tk;
        {set_mt, set_mo, set_st, set_so} = preset;
        @(posedge C50);
        #1;
        rst        = 1'b0;
        load       = 1'b0;
        start_stop = 1'b0;
        clk1hz     = 1'b0;
    endtask

    task automatic doLoad(input logic [15:0] preset);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, preset);
    endtask

    task automatic doStart();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    endtask

    task automatic doTick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    endtask

    function automatic logic [15:0] value();
        return {mt, mo, st, so};
    endfunction

    function automatic logic [15:0] flags();
        return {13'd0, running, done, expired};
    endfunction

    initial begin
        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("reset_value", value(), 16'h0000);
        checkOutput("reset_flags", flags(), 16'h0000);

        // Basic countdown 00:03
        doLoad(16'h0003);
        checkOutput("basic_load", value(), 16'h0003);
        doStart();
        checkOutput("basic_running", flags(), 16'h0004);
        doTick();
        checkOutput("basic_t1", value(), 16'h0002);
        doTick();
        checkOutput("basic_t2", value(), 16'h0001);
        checkOutput("basic_t2_flags", flags(), 16'h0004);
        doTick();
        checkOutput("basic_t3", value(), 16'h0000);
        checkOutput("basic_expire_flags", flags(), 16'h0003);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("basic_after_flags", flags(), 16'h0002);

        // Borrow chain
        doLoad(16'h1000);
        doStart();
        doTick();
        checkOutput("borrow_1000", value(), 16'h0959);
        doLoad(16'h0100);
        doStart();
        doTick();
        checkOutput("borrow_0100", value(), 16'h0059);

        // Sanitising presets 12:15:7:10
        doLoad(16'hCF7A);
        checkOutput("sanitise", value(), 16'h9959);
        checkOutput("sanitise_flags", flags(), 16'h0000);

        // Pause
        doLoad(16'h0005);
        doStart();
        doTick();
        checkOutput("pause_t1", value(), 16'h0004);
        doStart();
        checkOutput("pause_flags", flags(), 16'h0000);
        doTick();
        doTick();
        checkOutput("pause_hold", value(), 16'h0004);
        doStart();
        checkOutput("resume_flags", flags(), 16'h0004);
        doTick();
        checkOutput("resume_t", value(), 16'h0003);

        // Simultaneous events
        doLoad(16'h0005);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        checkOutput("ss_tick_value", value(), 16'h0005);
        checkOutput("ss_tick_flags", flags(), 16'h0004);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0009);
        checkOutput("load_ss_value", value(), 16'h0009);
        checkOutput("load_ss_flags", flags(), 16'h0000);
        doLoad(16'h0000);
        doStart();
        checkOutput("start_zero_flags", flags(), 16'h0000);
        doTick();
        checkOutput("start_zero_value", value(), 16'h0000);
        checkOutput("start_zero_tick_flags", flags(), 16'h0000);

        // Free-running ticks across a minute borrow
        doLoad(16'h0102);
        doStart();
        doTick();
        checkOutput("free_t1", value(), 16'h0101);
        doTick();
        checkOutput("free_t2", value(), 16'h0100);
        doTick();
        checkOutput("free_t3", value(), 16'h0059);

        // Reset during RUN, with a competing load
        doLoad(16'h0007);
        doStart();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0555);
        checkOutput("rst_run_value", value(), 16'h0000);
        checkOutput("rst_run_flags", flags(), 16'h0000);

        // Expiry with tick held, ticks in DONE ignored, then exit DONE
        doLoad(16'h0001);
        doStart();
        doTick();
        checkOutput("done_expire_flags", flags(), 16'h0003);
        doTick();
        checkOutput("done_tick_flags", flags(), 16'h0002);
        checkOutput("done_tick_value", value(), 16'h0000);
        doStart();
        checkOutput("done_exit_flags", flags(), 16'h0000);
        checkOutput("done_exit_value", value(), 16'h0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/timer_countdown_core.md
# timer_countdown_core

Countdown timer core for the digital timer, directly downstream of the 1 Hz tick generator. It consumes the one-C50-cycle `clk1hz` tick pulse, holds a BCD MM:SS value (00:00–99:59), and counts it down to 00:00 under start/pause control. It flags expiry, and its four BCD digits feed the seven-segment display stage.

## Interface
- No parameters; widths and limits are fixed (4-bit BCD per digit, seconds tens ≤ 5).
- `C50`  in  1  50 MHz system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clk1hz`  in  1  one-cycle tick pulse, synchronous to C50, nominally once per second; used as a clock enable, never as a clock.
- `load`  in  1  one-cycle pulse; loads the preset digits.
- `start_stop`  in  1  one-cycle pulse; toggles run/pause.
- `set_mt`, `set_mo`, `set_st`, `set_so`  in  4 each  preset minutes-tens, minutes-ones, seconds-tens, seconds-ones (BCD).
- `mt`, `mo`, `st`, `so`  out  4 each  current value, BCD, registered.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE (alarm level).
- `expired`  out  1  one-cycle pulse on entry to DONE.

## Operation
- **States:** IDLE, RUN, PAUSE, DONE. After reset: IDLE, all digits 0, `running`, `done` and `expired` all 0.
- **Per-cycle priority:** `rst` > `load` > `start_stop` > `clk1hz`. At most one action is taken per cycle.
- **load (any state):**
  - Each preset digit is sanitised: `set_mo`, `set_so`, `set_mt` values > 9 become 9; `set_st` > 5 becomes 5.
  - The sanitised digits are written to the outputs and the state goes to IDLE.
  - A `start_stop` or tick in the same cycle is ignored.
- **start_stop:**
  - IDLE → RUN if the value ≠ 00:00. If the value = 00:00, stay in IDLE with no pulse.
  - RUN → PAUSE; PAUSE → RUN.
  - DONE → IDLE, digits stay at 00:00, `done` clears.
  - A tick in the same cycle is ignored.
- **Tick in RUN** decrements the value by one second, with borrow:
  - `so` 0 → 9, borrowing from `st`.
  - `st` 0 → 5, borrowing from `mo`.
  - `mo` 0 → 9, borrowing from `mt`.
  - The value never goes below 00:00.
- **Reaching zero:** a tick in RUN with value 00:01 sets the value to 00:00 and the state to DONE. `expired` is high for exactly that next cycle, and `done` rises in the same cycle.
- **Ignored ticks:** ticks in IDLE, PAUSE and DONE change nothing.
- **Output state:** all outputs are registered; no combinational path from inputs to outputs. Digits never hold a non-BCD value or `st` > 5.

## Timing
- **Decrement latency:** a tick sampled at edge N produces the new digits after edge N, i.e. visible in cycle N+1.
- **State change latency:** 1 cycle from the sampled pulse (`running` follows the state register).
- **Expiry timing:** `expired` asserts in the same cycle the digits first show 00:00 and `done` first goes high. It lasts one cycle, even if `clk1hz` stays high.
- **Reset:** `rst` mid-count (any state) returns to IDLE, digits 00:00 and all flags 0 on the next edge. The preset is not retained.
- **Free-running ticks:** back-to-back ticks on consecutive cycles (tick held high) decrement once per cycle in RUN. The block does not require 1 s spacing.

## Test plan
- **Basic countdown:** reset, load 00:03, pulse `start_stop`, three ticks.
  - Digits go 00:02, 00:01, 00:00.
  - `expired` is high for one cycle aligned with 00:00; `done` = 1 and `running` = 0 afterwards.
- **Borrow chain:** load 10:00, start, one tick → 09:59. Load 01:00, start, tick → 00:59.
- **Sanitising:** load `set_mt`=12, `set_mo`=15, `set_st`=7, `set_so`=10 → 99:59 (`mt` clamps to 9).
- **Pause:**
  - Load 00:05, start, tick → 00:04.
  - Pulse `start_stop` (PAUSE), two ticks → still 00:04.
  - Pulse `start_stop`, tick → 00:03.
- **Simultaneous events:**
  - `start_stop` and tick in the same cycle from IDLE with 00:05 → RUN, still 00:05.
  - `load` 00:09 with `start_stop` in RUN → IDLE, 00:09.
  - Start with 00:00 → stays IDLE, `expired` never asserts.
- **Reset and DONE exit:**
  - `rst` during RUN at 00:07 → next cycle 00:00, IDLE, flags 0.
  - From DONE, `start_stop` → IDLE, `done` = 0.
